// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multicycle RV32I control FSM sharing one req/ready memory port.
// Define RV_ILLEGAL_TRAP_EN to make unknown opcodes halt instead of retiring as NOPs.
module rv_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       instr_done,
  output logic       halted
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;
  state_t state_q, state_d;
  logic pc_w, ir_w, reg_w, mem_w, done;
  logic [3:0] alu_dec;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  assign ImmSrc = (op == OP_SW) ? 2'd1 : (op == OP_BEQ) ? 2'd2 : (op == OP_JAL) ? 2'd3 : 2'd0;
  always_comb
    alu_dec = (funct3 == 3'b000) ? {3'b000, (op == OP_R) & funct7b5} :
              (funct3 == 3'b111) ? 4'd2 :
              (funct3 == 3'b110) ? 4'd3 :
              (funct3 == 3'b100) ? 4'd4 :
              (funct3 == 3'b010) ? 4'd5 : 4'd0;
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_w      = 1'b0;
    AdrSrc     = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    done       = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ResultSrc  = 2'd0;
    ALUControl = 4'd0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        ir_w      = mem_ready;
        pc_w      = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                  (op == OP_R)   ? S_EXECR :
                  (op == OP_I)   ? S_EXECI :
                  (op == OP_BEQ) ? S_BEQ :
                  (op == OP_JAL) ? S_JAL :
`ifdef RV_ILLEGAL_TRAP_EN
                  S_ILLEGAL;
`else
                  S_FETCH;
        done    = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
                    op == OP_BEQ || op == OP_JAL);
`endif
      end
      S_MEMADR: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'd1;
        reg_w     = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_w   = 1'b1;
        AdrSrc  = 1'b1;
        done    = mem_ready;
        state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = (state_q == S_EXECI) ? 2'd1 : 2'd0;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'd2;
        ALUControl = 4'd1;
        pc_w       = Zero;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        pc_w    = 1'b1;
        state_d = S_ALUWB;
      end
`ifdef RV_ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_ILLEGAL;
`endif
      default: state_d = S_FETCH;
    endcase
  end
  // Strobes are masked while reset is high since the FSM sits in FETCH during reset.
  assign PCWrite    = pc_w & ~reset;
  assign IRWrite    = ir_w & ~reset;
  assign RegWrite   = reg_w & ~reset;
  assign MemWrite   = mem_w & ~reset;
  assign instr_done = done & ~reset;
`ifdef RV_ILLEGAL_TRAP_EN
  assign halted = (state_q == S_ILLEGAL) & ~reset;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: randomized instruction stream checked against a per-instruction
// summary model (latency, strobe counts, selects) derived from the opcode and wait states.
module tb_rv_multicycle_ctrl;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111, BAD = 7'b0000000;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0, mem_ready = 1'b1;
  logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, instr_done, halted;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [3:0] ALUControl;
  int n_chk = 0, n_fail = 0;
  rv_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .instr_done(instr_done), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (o == BEQ) return 1;
    if (o != RT && o != IT) return 0;
    case (f3)
      3'b000:  return (o == RT && f7) ? 1 : 0;
      3'b111:  return 2;
      3'b110:  return 3;
      3'b100:  return 4;
      3'b010:  return 5;
      default: return 0;
    endcase
  endfunction
  // fw: not-ready cycles in FETCH; mw: not-ready cycles in the data access.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw);
    bit is_mem = (o == LW || o == SW);
    bit done = 0;
    int cyc = 0, pcw = 0, irw = 0, rgw = 0, mwc = 0, req = 0, adr = 0, hlt = 0;
    int rs = -1, alu = -1, imm = -1;
    int lat, e_pcw, e_rgw, e_imm;
    op = o; funct3 = f3; funct7b5 = f7;
    while (!done && cyc < 64) begin
      mem_ready = (cyc < fw) ? 1'b0 : (cyc == fw) ? 1'b1 :
                  (is_mem && cyc >= fw + 3 && cyc < fw + 3 + mw) ? 1'b0 :
                  (is_mem && cyc == fw + 3 + mw) ? 1'b1 : 1'($urandom);
      Zero = (cyc == fw + 2) ? z : 1'($urandom);
      @(negedge clk);
      pcw += int'(PCWrite); irw += int'(IRWrite); rgw += int'(RegWrite);
      mwc += int'(MemWrite); req += int'(mem_req); adr += int'(AdrSrc); hlt += int'(halted);
      if (cyc == 0) imm = int'(ImmSrc);
      if (cyc == fw + 2) alu = int'(ALUControl);
      if (RegWrite) rs = int'(ResultSrc);
      done = instr_done;
      cyc++;
      @(posedge clk); #1;
    end
    lat   = fw + ((o == LW) ? 5 + mw : (o == SW) ? 4 + mw : (o == BEQ) ? 3 :
                  (o == RT || o == IT || o == JAL) ? 4 : 2);
    e_pcw = 1 + int'(o == JAL) + int'(o == BEQ && z);
    e_rgw = int'(o == LW || o == RT || o == IT || o == JAL);
    e_imm = (o == SW) ? 1 : (o == BEQ) ? 2 : (o == JAL) ? 3 : 0;
    check("retired", done, 1);
    check("latency", cyc, lat);
    check("pcwrite_cnt", pcw, e_pcw);
    check("irwrite_cnt", irw, 1);
    check("regwrite_cnt", rgw, e_rgw);
    check("memwrite_cnt", mwc, (o == SW) ? mw + 1 : 0);
    check("memreq_cnt", req, fw + 1 + (is_mem ? mw + 1 : 0));
    check("adrsrc_cnt", adr, is_mem ? mw + 1 : 0);
    check("halted_cnt", hlt, 0);
    check("immsrc", imm, e_imm);
    check("resultsrc_wb", rs, e_rgw ? ((o == LW) ? 1 : 0) : -1);
    if (lat > fw + 2) check("alucontrol", alu, exp_alu(o, f3, f7));
  endtask
  initial begin
    logic [6:0] ops [7];
    ops = '{LW, SW, RT, IT, BEQ, JAL, BAD};
    @(negedge clk);
    check("rst_pcwrite", PCWrite, 0);
    check("rst_irwrite", IRWrite, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_done", instr_done, 0);
    check("rst_halted", halted, 0);
    check("rst_fetch_req", mem_req, 1);
    @(posedge clk); #1 reset = 1'b0;
    run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(LW, 3'b010, 1'b0, 1'b0, 2, 3);
    run_instr(SW, 3'b010, 1'b0, 1'b0, 1, 2);
    run_instr(BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(JAL, 3'b000, 1'b0, 1'b0, 0, 0);
`ifndef RV_ILLEGAL_TRAP_EN
    run_instr(BAD, 3'b000, 1'b0, 1'b0, 0, 0);
`endif
    for (int i = 0; i < 60; i++) begin
      int k;
`ifdef RV_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 5);
`else
      k = $urandom_range(0, 6);
`endif
      run_instr(ops[k], 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    op = SW; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("sw_memwrite_pre", MemWrite, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_memwrite", MemWrite, 0);
    check("midrst_done", instr_done, 0);
    check("midrst_fetch", {31'd0, mem_req & ~AdrSrc}, 1);
    @(posedge clk); #1 reset = 1'b0;
    run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0);
`ifdef RV_ILLEGAL_TRAP_EN
    op = BAD; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 mem_ready = 1'($urandom);
      @(negedge clk);
      check("trap_halted", halted, 1);
      check("trap_req", mem_req, 0);
      check("trap_done", instr_done, 0);
      @(posedge clk);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    check("trap_rst_halted", halted, 0);
    @(posedge clk); #1 reset = 1'b0;
    run_instr(IT, 3'b100, 1'b0, 1'b0, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
